sd_quad_osc: RTL and testbench

Parametrised sigma-delta quadrature oscillator. It is the successor to the fixed single-omega sine/cosine generator. Two cross-coupled saturating integrators are driven by internal first-order sigma-delta modulators, producing sine and cosine bitstreams plus their multibit views. Additions over the previous generation:
- run/idle control
- phase restart
- glitch-free omega retune through a valid/ready handshake, applied at a sine zero crossing
- saturation reporting

---
 rtl/sd_quad_osc.sv | 177 +++++++++++++++++
 tb/tb_sd_quad_osc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_quad_osc.sv
`timescale 1ns/1ps
// sd_quad_osc: sigma-delta quadrature oscillator.
// Two cross-coupled saturating integrators (x1 = cosine, x2 = sine) are each
// fed back through a first-order 1-bit sigma-delta modulator. Omega retunes
// through a valid/ready handshake and takes effect at an upward sine zero
// crossing, so the waveform never jumps.
// Build option: define SD_QUAD_SAT_CNT_EN to add sat_cnt, a 16-bit saturating
// count of clamp events.
module sd_quad_osc #(
  parameter int SD_IN_BW  = 16,
  parameter int INT_SCALE = 20,
  parameter int OMEGA_BW  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       restart,
  input  logic signed [OMEGA_BW-1:0] omega_in,
  input  logic                       omega_valid,
  output logic                       omega_ready,
  output logic                       sin,
  output logic                       cos,
  output logic signed [SD_IN_BW-1:0] sinx,
  output logic signed [SD_IN_BW-1:0] cosx,
  output logic [1:0]                 state,
  output logic                       sat_sin,
  output logic                       sat_cos
`ifdef SD_QUAD_SAT_CNT_EN
  ,
  output logic [15:0]                sat_cnt
`endif
);
  // state | meaning
  // IDLE  | everything frozen; a handshake loads omega directly
  // RUN   | oscillating; a handshake parks the new omega and moves to PEND
  // PEND  | oscillating; parked omega applied at the next upward x2 zero crossing

  localparam int REG_BW = SD_IN_BW + INT_SCALE + 1;
  localparam int SUM_BW = REG_BW + 1;
  localparam int ACC_BW = SD_IN_BW + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  // Clamp to the range where the top two integrator bits agree. The sinx/cosx
  // slice drops bit REG_BW-2, so this keeps the slice wrap-free and maps the
  // positive limit to full-scale 0x7FFF.
  localparam logic signed [REG_BW-1:0] LIM    = {2'b00, {(REG_BW-2){1'b1}}};
  localparam logic signed [REG_BW-1:0] NLIM   = {2'b11, {(REG_BW-2){1'b0}}};
  localparam logic signed [SUM_BW-1:0] SUM_HI = {3'b000, {(REG_BW-2){1'b1}}};
  localparam logic signed [SUM_BW-1:0] SUM_LO = {3'b111, {(REG_BW-2){1'b0}}};
  localparam logic signed [ACC_BW-1:0] FS     = {3'b001, {(SD_IN_BW-1){1'b0}}};

  logic signed [REG_BW-1:0]   x1, x2, g, fb_sin, fb_cos, nx1, nx2;
  logic signed [SUM_BW-1:0]   sum1, sum2;
  logic signed [OMEGA_BW-1:0] omega_q, omega_pend;
  logic signed [ACC_BW-1:0]   acc_s, acc_c, u_s, u_c, acc_s_n, acc_c_n;
  logic                       clip1, clip2, x2_rise, running, hs;

  assign sinx        = {x2[REG_BW-1], x2[REG_BW-3:INT_SCALE]};
  assign cosx        = {x1[REG_BW-1], x1[REG_BW-3:INT_SCALE]};
  assign omega_ready = (state != ST_PEND);
  assign hs          = omega_valid & omega_ready;
  assign running     = (state == ST_RUN) || (state == ST_PEND);

  // Integrator feedback from the bitstreams, widened sums and clamping.
  always_comb begin
    g      = {{(REG_BW-OMEGA_BW){omega_q[OMEGA_BW-1]}}, omega_q} <<< SD_IN_BW;
    fb_sin = sin ? -g : g;
    fb_cos = cos ? g : -g;
    sum1   = {x1[REG_BW-1], x1} + {fb_sin[REG_BW-1], fb_sin};
    sum2   = {x2[REG_BW-1], x2} + {fb_cos[REG_BW-1], fb_cos};
    clip1  = (sum1 > SUM_HI) || (sum1 < SUM_LO);
    clip2  = (sum2 > SUM_HI) || (sum2 < SUM_LO);
    if (sum1 > SUM_HI)      nx1 = LIM;
    else if (sum1 < SUM_LO) nx1 = NLIM;
    else                    nx1 = sum1[REG_BW-1:0];
    if (sum2 > SUM_HI)      nx2 = LIM;
    else if (sum2 < SUM_LO) nx2 = NLIM;
    else                    nx2 = sum2[REG_BW-1:0];
    x2_rise = x2[REG_BW-1] & ~nx2[REG_BW-1];
  end

  // First-order modulator accumulator updates for both channels.
  always_comb begin
    u_s     = {{2{sinx[SD_IN_BW-1]}}, sinx};
    u_c     = {{2{cosx[SD_IN_BW-1]}}, cosx};
    acc_s_n = acc_s + u_s - (sin ? FS : -FS);
    acc_c_n = acc_c + u_c - (cos ? FS : -FS);
  end

  // Datapath registers: integrators, modulators, bitstreams, clamp pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1      <= LIM;
      x2      <= '0;
      acc_s   <= '0;
      acc_c   <= '0;
      sin     <= 1'b0;
      cos     <= 1'b0;
      sat_sin <= 1'b0;
      sat_cos <= 1'b0;
    end else if (restart) begin
      x1      <= LIM;
      x2      <= '0;
      acc_s   <= '0;
      acc_c   <= '0;
      sin     <= 1'b0;
      cos     <= 1'b0;
      sat_sin <= 1'b0;
      sat_cos <= 1'b0;
    end else if (running) begin
      x1      <= nx1;
      x2      <= nx2;
      acc_s   <= acc_s_n;
      acc_c   <= acc_c_n;
      sin     <= ~acc_s_n[ACC_BW-1];
      cos     <= ~acc_c_n[ACC_BW-1];
      sat_sin <= clip2;
      sat_cos <= clip1;
    end else begin
      sat_sin <= 1'b0;
      sat_cos <= 1'b0;
    end
  end

  // Control FSM and omega staging; restart and IDLE entry flush any parked omega.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      omega_q    <= '0;
      omega_pend <= '0;
    end else if (restart) begin
      state <= en ? ST_RUN : ST_IDLE;
      if (hs)                    omega_q <= omega_in;
      else if (state == ST_PEND) omega_q <= omega_pend;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) omega_q <= omega_in;
          if (en) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!en) begin
            state <= ST_IDLE;
            if (hs) omega_q <= omega_in;
          end else if (hs) begin
            omega_pend <= omega_in;
            state      <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (!en || x2_rise) begin
            omega_q <= omega_pend;
            state   <= en ? ST_RUN : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SD_QUAD_SAT_CNT_EN
  logic [16:0] sat_cnt_sum;
  assign sat_cnt_sum = {1'b0, sat_cnt} + {15'd0, sat_sin} + {15'd0, sat_cos};

  // Clamp-event counter, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  sat_cnt <= '0;
    else if (restart)         sat_cnt <= '0;
    else if (sat_cnt_sum[16]) sat_cnt <= 16'hFFFF;
    else                      sat_cnt <= sat_cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_sd_quad_osc.sv
`timescale 1ns/1ps
// Scoreboard bench for sd_quad_osc: stimulus pushes expectations, a negedge
// monitor tracks zero-crossing periods, peaks, clamp pulses and wraps and
// retires the expectations.
module tb_sd_quad_osc;
  logic               clk = 1'b0;
  logic               rst, en, restart, omega_valid;
  logic signed [15:0] omega_in;
  logic               omega_ready, sin, cos, sat_sin, sat_cos;
  logic signed [15:0] sinx, cosx;
  logic [1:0]         state;
`ifdef SD_QUAD_SAT_CNT_EN
  logic [15:0]        sat_cnt;
`endif

  always #5 clk = ~clk;

  sd_quad_osc dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .omega_in(omega_in), .omega_valid(omega_valid), .omega_ready(omega_ready),
    .sin(sin), .cos(cos), .sinx(sinx), .cosx(cosx), .state(state),
    .sat_sin(sat_sin), .sat_cos(sat_cos)
`ifdef SD_QUAD_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  localparam int K_SINX = 0, K_COSX = 1, K_SIN = 2, K_COS = 3, K_STATE = 4,
                 K_READY = 5, K_SATSIN = 6, K_SATCOS = 7, K_NSATS = 8,
                 K_NSATC = 9, K_JUMPS = 10, K_PEAK = 11, K_PERIOD = 12;

  typedef struct {
    string name;
    int    kind;
    int    due;
    int    lo;
    int    hi;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0;

  // monitor state
  int s_now, prev_s, last_cross, period, peak, nsats, nsatc, jumps;
  bit last_valid = 0, armed = 0, prev_valid = 0, cross_ev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_compare(input string name, input int obs, input int lo, input int hi);
    checks++;
    if (obs < lo || obs > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, obs, lo, hi, cyc);
    end
  endtask

  task automatic expect_now(input string name, input int kind, input int lo, input int hi);
    exp_t e;
    e.name = name; e.kind = kind; e.due = cyc; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic expect_period(input string name, input int nom, input int budget);
    exp_t e;
    e.name = name; e.kind = K_PERIOD; e.due = cyc + budget;
    e.lo = nom * 98 / 100; e.hi = nom * 102 / 100;
    sb.push_back(e);
  endtask

  function automatic int observe(input int kind);
    case (kind)
      K_SINX:   return int'(sinx);
      K_COSX:   return int'(cosx);
      K_SIN:    return int'(sin);
      K_COS:    return int'(cos);
      K_STATE:  return int'(state);
      K_READY:  return int'(omega_ready);
      K_SATSIN: return int'(sat_sin);
      K_SATCOS: return int'(sat_cos);
      K_NSATS:  return nsats;
      K_NSATC:  return nsatc;
      K_JUMPS:  return jumps;
      K_PEAK:   return peak;
      default:  return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    s_now    = int'(sinx);
    cross_ev = 0;
    if (rst || restart) begin
      last_valid = 0; armed = 0; prev_valid = 0;
      peak = 0; nsats = 0; nsatc = 0; jumps = 0;
    end else begin
      if (state == 2'd0) begin
        last_valid = 0; armed = 0;
      end
      if (sat_sin) nsats++;
      if (sat_cos) nsatc++;
      if (prev_valid && ((s_now - prev_s > 16384) || (prev_s - s_now > 16384))) jumps++;
      if ((s_now < 0 ? -s_now : s_now) > peak) peak = (s_now < 0 ? -s_now : s_now);
      if (s_now < -8192) armed = 1;
      else if (armed && s_now >= 0) begin
        armed = 0;
        if (last_valid) begin
          period   = cyc - last_cross;
          cross_ev = 1;
        end
        last_cross = cyc;
        last_valid = 1;
      end
      prev_s = s_now; prev_valid = 1;
    end
    while (sb.size() > 0) begin
      if (sb[0].kind == K_PERIOD) begin
        if (cross_ev) begin
          do_compare(sb[0].name, period, sb[0].lo, sb[0].hi);
          void'(sb.pop_front());
          cross_ev = 0;
        end else if (cyc > sb[0].due) begin
          checks++; failures++;
          $display("FAIL %s: got no crossing by cycle %0d, expected period %0d..%0d",
                   sb[0].name, cyc, sb[0].lo, sb[0].hi);
          void'(sb.pop_front());
        end else break;
      end else if (sb[0].due <= cyc) begin
        do_compare(sb[0].name, observe(sb[0].kind), sb[0].lo, sb[0].hi);
        void'(sb.pop_front());
      end else break;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      step(); n++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: got %0d items left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic expect_reset_view(input string tag);
    expect_now({tag, "_cosx"}, K_COSX, 32767, 32767);
    expect_now({tag, "_sinx"}, K_SINX, 0, 0);
    expect_now({tag, "_sin"}, K_SIN, 0, 0);
    expect_now({tag, "_cos"}, K_COS, 0, 0);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    bit  found;
    rst = 1'b1; en = 1'b0; restart = 1'b0; omega_valid = 1'b0; omega_in = '0;

    // reset view, then idle hold
    step(); step();
    expect_reset_view("rst");
    expect_now("rst_state", K_STATE, 0, 0);
    expect_now("rst_ready", K_READY, 1, 1);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      expect_reset_view("idle_hold");
      expect_now("idle_hold_state", K_STATE, 0, 0);
    end
    wait_empty(10);

    // omega handshake while idle
    omega_in = 16'sd512; omega_valid = 1'b1;
    expect_now("idle_hs_ready", K_READY, 1, 1);
    expect_now("idle_hs_state", K_STATE, 0, 0);
    step();
    omega_valid = 1'b0;
    expect_now("idle_after_hs_state", K_STATE, 0, 0);
    expect_now("idle_after_hs_ready", K_READY, 1, 1);
    expect_now("idle_after_hs_sinx", K_SINX, 0, 0);
    step();
    en = 1'b1;
    step();
    expect_now("run_state", K_STATE, 1, 1);
    expect_period("period_512", 6434, 20000);
    wait_empty(25000);
    expect_now("peak_512", K_PEAK, 28672, 32768);
    wait_empty(10);

    // retune to 1024 while sine is negative and falling
    n = 0;
    while (!(state == 2'd1 && sinx < -16'sd4096 && cosx < 0) && n < 20000) begin
      step(); n++;
    end
    do_compare("retune_window_found", int'(n < 20000), 1, 1);
    omega_in = 16'sd1024; omega_valid = 1'b1;
    expect_now("retune_ready", K_READY, 1, 1);
    step();
    omega_valid = 1'b0;
    expect_now("pend_state", K_STATE, 2, 2);
    expect_now("pend_ready", K_READY, 0, 0);
    found = 0; n = 0;
    while (!found && n < 8000) begin
      step(); n++;
      if (sinx < 0) begin
        expect_now("pend_hold_state", K_STATE, 2, 2);
        expect_now("pend_hold_ready", K_READY, 0, 0);
      end else begin
        expect_now("pend_cross_state", K_STATE, 1, 1);
        found = 1;
      end
    end
    do_compare("pend_cross_seen", int'(found), 1, 1);
    step();
    expect_now("post_cross_ready", K_READY, 1, 1);
    expect_now("post_cross_state", K_STATE, 1, 1);
    step();
    expect_period("period_1024", 3217, 8000);
    wait_empty(10000);

    // restart mid-run with same-cycle handshake
    repeat (300) step();
    restart = 1'b1; omega_valid = 1'b1; omega_in = 16'sd256;
    expect_now("restart_hs_ready", K_READY, 1, 1);
    step();
    restart = 1'b0; omega_valid = 1'b0;
    expect_reset_view("restart");
    expect_now("restart_state", K_STATE, 1, 1);
    expect_now("restart_ready", K_READY, 1, 1);
    expect_period("period_256", 12868, 30000);
    wait_empty(35000);

    // maximum omega: clamping, no wrap
    restart = 1'b1; omega_valid = 1'b1; omega_in = 16'sh7FFF;
    step();
    restart = 1'b0; omega_valid = 1'b0;
    repeat (2000) step();
    expect_now("sat_sin_pulses", K_NSATS, 1, 1 << 30);
    expect_now("sat_cos_pulses", K_NSATC, 1, 1 << 30);
    expect_now("no_wrap_jumps", K_JUMPS, 0, 0);
    wait_empty(10);

    // async reset while PEND
    n = 0;
    while (!(state == 2'd1 && sinx < -16'sd12288 && cosx < 0) && n < 5000) begin
      step(); n++;
    end
    do_compare("pend2_window_found", int'(n < 5000), 1, 1);
    omega_in = 16'sd512; omega_valid = 1'b1;
    step();
    omega_valid = 1'b0;
    do_compare("pend_before_rst", int'(state), 2, 2);
    #2;
    rst = 1'b1;
    expect_reset_view("async_rst");
    expect_now("async_rst_state", K_STATE, 0, 0);
    expect_now("async_rst_ready", K_READY, 1, 1);
    expect_now("async_rst_sat_sin", K_SATSIN, 0, 0);
    expect_now("async_rst_sat_cos", K_SATCOS, 0, 0);
    step(); step();
    rst = 1'b0;
    repeat (300) step();
    expect_now("zero_omega_sinx", K_SINX, 0, 0);
    expect_now("zero_omega_cosx", K_COSX, 32767, 32767);
    expect_now("zero_omega_state", K_STATE, 1, 1);
    wait_empty(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
